// File: rtl/dsp48_pkg.sv
// Shared constants and helpers for the DSP48E1 slice operand path.
package dsp48_pkg;
   localparam int    MAX_OPERAND_W  = 30;
   localparam int    MAX_PIPE_DEPTH = 4;
   localparam string SEL_DIRECT     = "DIRECT";
   localparam string SEL_CASCADE    = "CASCADE";

   // Tap indices beyond the built depth fall back to the last stage.
   function automatic int clamp_tap(input logic [2:0] sel, input int depth);
      return (int'(sel) > depth) ? depth : int'(sel);
   endfunction
endpackage

// File: rtl/dsp_pipe_stage.sv
// One operand pipeline stage: data and valid registered together.
module dsp_pipe_stage #(
   parameter int W = 19
) (
   input  logic         clk,
   input  logic         RST_n,
   input  logic         clr,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)   q <= '0;
      else if (clr) q <= '0;
      else if (ce)  q <= d;
   end
endmodule

// File: rtl/dsp_operand_pipe.sv
// Parametrised A/B operand pipeline with per-stage enables, valid tracking,
// a static cascade tap and a dynamically selected multiplier tap.
module dsp_operand_pipe
   import dsp48_pkg::*;
#(
   parameter int    WIDTH     = 18,
   parameter int    DEPTH     = 2,
   parameter string INPUT_SEL = "DIRECT",
   parameter int    CASC_TAP  = DEPTH,
   localparam int   CE_W      = (DEPTH > 0) ? DEPTH : 1
) (
   input  logic             clk,
   input  logic             RST_n,
   input  logic             clr,
   input  logic [CE_W-1:0]  ce,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] cin,
   input  logic             in_valid,
   input  logic [2:0]       tap_sel,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] dout_mult,
   output logic [WIDTH-1:0] cout,
   output logic             dout_valid,
   output logic             mult_valid,
   output logic [2:0]       occupancy
);
   // Index 0 is the combinational selected input, 1..DEPTH are registers.
   logic [DEPTH:0][WIDTH-1:0] s;
   logic [DEPTH:0]            v;

   if (WIDTH < 1 || WIDTH > MAX_OPERAND_W) begin : g_bad_width
      $error("dsp_operand_pipe: WIDTH out of range");
   end
   if (DEPTH < 0 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
      $error("dsp_operand_pipe: DEPTH out of range");
   end
   if (CASC_TAP < 0 || CASC_TAP > DEPTH) begin : g_bad_casc
      $error("dsp_operand_pipe: CASC_TAP exceeds DEPTH");
   end

   if (INPUT_SEL == SEL_CASCADE) begin : g_in_casc
      logic unused_din;
      assign unused_din = ^din;
      assign s[0]       = cin;
   end else begin : g_in_direct
      if (INPUT_SEL != SEL_DIRECT) begin : g_bad_sel
         $error("dsp_operand_pipe: INPUT_SEL must be DIRECT or CASCADE");
      end
      logic unused_cin;
      assign unused_cin = ^cin;
      assign s[0]       = din;
   end
   assign v[0] = in_valid;

   if (DEPTH == 0) begin : g_comb
      logic unused_ctl;
      assign unused_ctl = ^{clk, RST_n, clr, ce};
   end else begin : g_pipe
      for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
         logic [WIDTH:0] q;
         dsp_pipe_stage #(.W(WIDTH + 1)) u_stage (
            .clk   (clk),
            .RST_n (RST_n),
            .clr   (clr),
            .ce    (ce[k-1]),
            .d     ({v[k-1], s[k-1]}),
            .q     (q)
         );
         assign {v[k], s[k]} = q;
      end
   end

   assign dout       = s[DEPTH];
   assign dout_valid = v[DEPTH];
   assign cout       = s[CASC_TAP];

   // Select path is unregistered so tap_sel changes land in the same cycle.
   always_comb begin
      int tap_idx;
      tap_idx    = clamp_tap(tap_sel, DEPTH);
      dout_mult  = '0;
      mult_valid = 1'b0;
      for (int k = 0; k <= DEPTH; k++) begin
         if (k == tap_idx) begin
            dout_mult  = s[k];
            mult_valid = v[k];
         end
      end
   end

   always_comb begin
      occupancy = 3'd0;
      for (int k = 1; k <= DEPTH; k++) begin
         if (v[k]) occupancy = occupancy + 3'd1;
      end
   end
endmodule

// File: tb/tb_dsp_operand_pipe.sv
// Bench for dsp_operand_pipe: four configurations sharing operand inputs.
module tb_dsp_operand_pipe;
   logic        clk = 1'b0, RST_n = 1'b0, clr = 1'b0, in_valid = 1'b0;
   logic [17:0] din = '0, cin = '0;
   logic [2:0]  tap_sel = '0;
   logic [1:0]  ce_a = '0;
   logic [2:0]  ce_b = '0;
   logic [1:0]  ce_c = '0;
   logic [0:0]  ce_d = '0;
   int total = 0, bad = 0;

   logic [17:0] dout_o[4], mult_o[4], cout_o[4];
   logic        dv_o[4], mv_o[4];
   logic [2:0]  occ_o[4];

   always #5 clk = ~clk;

   // a: DEPTH 2 direct; b: DEPTH 3 direct cout=stage1; c: DEPTH 2 cascade cout=stage1; d: DEPTH 0
   dsp_operand_pipe #(.WIDTH(18), .DEPTH(2), .INPUT_SEL("DIRECT")) u_a (
      .clk(clk), .RST_n(RST_n), .clr(clr), .ce(ce_a), .din(din), .cin(cin), .in_valid(in_valid),
      .tap_sel(tap_sel), .dout(dout_o[0]), .dout_mult(mult_o[0]), .cout(cout_o[0]),
      .dout_valid(dv_o[0]), .mult_valid(mv_o[0]), .occupancy(occ_o[0]));
   dsp_operand_pipe #(.WIDTH(18), .DEPTH(3), .INPUT_SEL("DIRECT"), .CASC_TAP(1)) u_b (
      .clk(clk), .RST_n(RST_n), .clr(clr), .ce(ce_b), .din(din), .cin(cin), .in_valid(in_valid),
      .tap_sel(tap_sel), .dout(dout_o[1]), .dout_mult(mult_o[1]), .cout(cout_o[1]),
      .dout_valid(dv_o[1]), .mult_valid(mv_o[1]), .occupancy(occ_o[1]));
   dsp_operand_pipe #(.WIDTH(18), .DEPTH(2), .INPUT_SEL("CASCADE"), .CASC_TAP(1)) u_c (
      .clk(clk), .RST_n(RST_n), .clr(clr), .ce(ce_c), .din(din), .cin(cin), .in_valid(in_valid),
      .tap_sel(tap_sel), .dout(dout_o[2]), .dout_mult(mult_o[2]), .cout(cout_o[2]),
      .dout_valid(dv_o[2]), .mult_valid(mv_o[2]), .occupancy(occ_o[2]));
   dsp_operand_pipe #(.WIDTH(18), .DEPTH(0), .INPUT_SEL("DIRECT")) u_d (
      .clk(clk), .RST_n(RST_n), .clr(clr), .ce(ce_d), .din(din), .cin(cin), .in_valid(in_valid),
      .tap_sel(tap_sel), .dout(dout_o[3]), .dout_mult(mult_o[3]), .cout(cout_o[3]),
      .dout_valid(dv_o[3]), .mult_valid(mv_o[3]), .occupancy(occ_o[3]));

   typedef struct {
      logic [17:0] din;  logic vld; logic [1:0] ce; logic [2:0] tap;
      logic [17:0] e_dout; logic e_dv; logic [17:0] e_mult; logic e_mv; logic [2:0] e_occ;
   } vec_t;
   vec_t tbl[7];

   // Reference model: per-configuration stage contents as plain arrays.
   int          dep[4] = '{2, 3, 2, 0};
   int          ctap[4] = '{2, 1, 1, 0};
   bit          casc[4] = '{0, 0, 1, 0};
   logic [17:0] ms[4][5];
   logic        mvb[4][5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      ce_a = '0; ce_b = '0; ce_c = '0; ce_d = '0; clr = 1'b0;
      RST_n = 1'b0;
      #12;
      @(negedge clk) RST_n = 1'b1;
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 5; k++) begin ms[i][k] = '0; mvb[i][k] = 1'b0; end
   endtask

   task automatic model_edge();
      logic [3:0] cev[4];
      cev[0] = {2'b0, ce_a}; cev[1] = {1'b0, ce_b}; cev[2] = {2'b0, ce_c}; cev[3] = {3'b0, ce_d};
      for (int i = 0; i < 4; i++) begin
         ms[i][0] = casc[i] ? cin : din;
         mvb[i][0] = in_valid;
         for (int k = dep[i]; k >= 1; k--) begin
            if (clr) begin ms[i][k] = '0; mvb[i][k] = 1'b0; end
            else if (cev[i][k-1]) begin ms[i][k] = ms[i][k-1]; mvb[i][k] = mvb[i][k-1]; end
         end
      end
   endtask

   task automatic model_check(input int cyc);
      for (int i = 0; i < 4; i++) begin
         int tp, occ;
         ms[i][0] = casc[i] ? cin : din;
         mvb[i][0] = in_valid;
         tp = (int'(tap_sel) > dep[i]) ? dep[i] : int'(tap_sel);
         occ = 0;
         for (int k = 1; k <= dep[i]; k++) occ += int'(mvb[i][k]);
         chk($sformatf("rnd c%0d i%0d dout", cyc, i), 32'(dout_o[i]), 32'(ms[i][dep[i]]));
         chk($sformatf("rnd c%0d i%0d dv", cyc, i), 32'(dv_o[i]), 32'(mvb[i][dep[i]]));
         chk($sformatf("rnd c%0d i%0d mult", cyc, i), 32'(mult_o[i]), 32'(ms[i][tp]));
         chk($sformatf("rnd c%0d i%0d mv", cyc, i), 32'(mv_o[i]), 32'(mvb[i][tp]));
         chk($sformatf("rnd c%0d i%0d cout", cyc, i), 32'(cout_o[i]), 32'(ms[i][ctap[i]]));
         chk($sformatf("rnd c%0d i%0d occ", cyc, i), 32'(occ_o[i]), 32'(occ));
      end
   endtask

   initial begin
      //        din   vld  ce     tap   dout  dv    mult  mv    occ
      tbl[0] = '{18'd5, 1'b1, 2'b11, 3'd1, 18'd0, 1'b0, 18'd5, 1'b1, 3'd1};
      tbl[1] = '{18'd5, 1'b1, 2'b11, 3'd1, 18'd5, 1'b1, 18'd5, 1'b1, 3'd2};
      tbl[2] = '{18'd9, 1'b0, 2'b11, 3'd0, 18'd5, 1'b1, 18'd9, 1'b0, 3'd1};
      tbl[3] = '{18'd3, 1'b1, 2'b11, 3'd7, 18'd9, 1'b0, 18'd9, 1'b0, 3'd1};
      tbl[4] = '{18'd4, 1'b1, 2'b01, 3'd1, 18'd9, 1'b0, 18'd4, 1'b1, 3'd1};
      tbl[5] = '{18'd6, 1'b0, 2'b10, 3'd2, 18'd4, 1'b1, 18'd4, 1'b1, 3'd2};
      tbl[6] = '{18'd1, 1'b0, 2'b00, 3'd0, 18'd4, 1'b1, 18'd1, 1'b0, 3'd2};

      // Reset state and asynchronous mid-cycle reset
      tap_sel = 3'd1;
      #2;
      chk("rst dout", 32'(dout_o[0]), 32'd0);
      chk("rst dv", 32'(dv_o[0]), 32'd0);
      chk("rst occ", 32'(occ_o[0]), 32'd0);
      @(negedge clk) RST_n = 1'b1;
      din = 18'h3FFFF; in_valid = 1'b1; ce_a = 2'b11; ce_b = 3'b111;
      step(); step(); step();
      chk("pre-rst dout", 32'(dout_o[0]), 32'h3FFFF);
      #3 RST_n = 1'b0;
      #1;
      chk("async rst dout", 32'(dout_o[0]), 32'd0);
      chk("async rst cout", 32'(cout_o[0]), 32'd0);
      chk("async rst mult", 32'(mult_o[0]), 32'd0);
      chk("async rst occ", 32'(occ_o[0]), 32'd0);
      chk("async rst b dout", 32'(dout_o[1]), 32'd0);
      @(negedge clk) RST_n = 1'b1;
      step();
      chk("post-rst stage1", 32'(mult_o[0]), 32'h3FFFF);
      chk("post-rst stage2", 32'(dout_o[0]), 32'd0);

      // Table-driven DEPTH=2 latency, tap clamp and stall rows
      do_reset();
      foreach (tbl[r]) begin
         din = tbl[r].din; in_valid = tbl[r].vld; ce_a = tbl[r].ce; tap_sel = tbl[r].tap;
         step();
         chk($sformatf("tbl%0d dout", r), 32'(dout_o[0]), 32'(tbl[r].e_dout));
         chk($sformatf("tbl%0d dv", r), 32'(dv_o[0]), 32'(tbl[r].e_dv));
         chk($sformatf("tbl%0d mult", r), 32'(mult_o[0]), 32'(tbl[r].e_mult));
         chk($sformatf("tbl%0d mv", r), 32'(mv_o[0]), 32'(tbl[r].e_mv));
         chk($sformatf("tbl%0d occ", r), 32'(occ_o[0]), 32'(tbl[r].e_occ));
         chk($sformatf("tbl%0d cout", r), 32'(cout_o[0]), 32'(tbl[r].e_dout));
      end

      // Mid-pipe stall on DEPTH=3
      do_reset();
      tap_sel = 3'd2; ce_b = 3'b111; in_valid = 1'b1;
      din = 18'd7; step();
      din = 18'd9; step();
      ce_b = 3'b101; din = 18'd13; step();
      chk("stall stage2", 32'(mult_o[1]), 32'd7);
      chk("stall dout", 32'(dout_o[1]), 32'd7);
      chk("stall cout", 32'(cout_o[1]), 32'd13);
      chk("stall occ", 32'(occ_o[1]), 32'd3);
      step();
      chk("stall hold dout", 32'(dout_o[1]), 32'd7);
      chk("stall hold stage2", 32'(mult_o[1]), 32'd7);
      chk("stall hold occ", 32'(occ_o[1]), 32'd3);

      // clr beats ce
      do_reset();
      ce_a = 2'b11; ce_b = 3'b111; din = 18'd12; in_valid = 1'b1; tap_sel = 3'd1;
      step(); step(); step();
      chk("full a dout", 32'(dout_o[0]), 32'd12);
      chk("full a occ", 32'(occ_o[0]), 32'd2);
      chk("full b occ", 32'(occ_o[1]), 32'd3);
      clr = 1'b1; step(); clr = 1'b0;
      chk("clr a dout", 32'(dout_o[0]), 32'd0);
      chk("clr a dv", 32'(dv_o[0]), 32'd0);
      chk("clr a mult", 32'(mult_o[0]), 32'd0);
      chk("clr a occ", 32'(occ_o[0]), 32'd0);
      chk("clr b dout", 32'(dout_o[1]), 32'd0);
      chk("clr b occ", 32'(occ_o[1]), 32'd0);

      // Cascade input with clamped multiplier tap
      do_reset();
      ce_c = 2'b11; cin = 18'd100; din = 18'd55; in_valid = 1'b1; tap_sel = 3'd7;
      #1;
      chk("casc cout at reset", 32'(cout_o[2]), 32'd0);
      step();
      chk("casc cout 1 edge", 32'(cout_o[2]), 32'd100);
      chk("casc dout 1 edge", 32'(dout_o[2]), 32'd0);
      step();
      chk("casc dout", 32'(dout_o[2]), 32'd100);
      chk("casc mult clamp", 32'(mult_o[2]), 32'd100);
      chk("casc dv", 32'(dv_o[2]), 32'd1);

      // DEPTH=0 pass-through ignores clr and ce
      din = 18'd42; in_valid = 1'b1; clr = 1'b1; ce_d = 1'b1; tap_sel = 3'd3;
      #1;
      chk("d0 dout", 32'(dout_o[3]), 32'd42);
      chk("d0 dv", 32'(dv_o[3]), 32'd1);
      chk("d0 mult", 32'(mult_o[3]), 32'd42);
      chk("d0 cout", 32'(cout_o[3]), 32'd42);
      chk("d0 occ", 32'(occ_o[3]), 32'd0);
      step();
      chk("d0 dout after clr edge", 32'(dout_o[3]), 32'd42);
      chk("d0 dv after clr edge", 32'(dv_o[3]), 32'd1);
      clr = 1'b0;

      // Randomized run against the array model
      do_reset();
      model_clear();
      for (int c = 0; c < 300; c++) begin
         din = 18'($urandom); cin = 18'($urandom);
         in_valid = 1'($urandom); tap_sel = 3'($urandom_range(0, 7));
         clr = ($urandom_range(0, 15) == 0);
         ce_a = 2'($urandom); ce_b = 3'($urandom); ce_c = 2'($urandom); ce_d = 1'($urandom);
         @(posedge clk);
         model_edge();
         #1;
         model_check(c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dsp_operand_pipe.md
# dsp_operand_pipe

Parametrised operand input pipeline for the DSP48E1 slice model; the next generation of the dual A/B input register. It supports a configurable operand width and register depth (0–4 stages), direct or cascade input, and an independent clock enable per stage. It provides a static cascade-out tap, a dynamically selectable multiplier tap, and a valid bit tracked through every stage. It sits between the slice operand pins (A/B or BCIN/ACIN) and the pre-adder/multiplier, and replaces fixed two-stage instances.

## Interface
- WIDTH, 18, operand width in bits (1–30).
- DEPTH, 2, number of pipeline stages (0–4); 0 gives a combinational pass-through.
- INPUT_SEL, "DIRECT", "DIRECT" selects din; "CASCADE" selects cin.
- CASC_TAP, DEPTH, stage index driven on cout (0..DEPTH); 0 means the selected input.
- clk  input  1  clock; all state updates on the rising edge.
- RST_n  input  1  asynchronous, active-low reset; clears every stage register and valid bit.
- clr  input  1  synchronous clear; same effect as reset at the next edge; overrides ce.
- ce  input  max(DEPTH,1)  per-stage clock enable; ce[k-1] loads stage k.
- din  input  WIDTH  direct operand.
- cin  input  WIDTH  cascade operand from the upstream slice.
- in_valid  input  1  qualifies the selected input this cycle.
- tap_sel  input  3  dynamic multiplier tap (stage index); sampled combinationally.
- dout  output  WIDTH  last stage (stage DEPTH) to the X/Y multiplexers.
- dout_mult  output  WIDTH  stage tap_sel (clamped) to the pre-adder/multiplier.
- cout  output  WIDTH  stage CASC_TAP to the downstream slice.
- dout_valid  output  1  valid bit of stage DEPTH.
- mult_valid  output  1  valid bit of the tap_sel stage.
- occupancy  output  3  count of set valid bits across stages 1..DEPTH.

## Operation
- Stage 0 is the combinational selected input: S0 = (INPUT_SEL=="CASCADE") ? cin : din, with V0 = in_valid.
- Stage k, k=1..DEPTH, updates each edge with priority RST_n low > clr > ce[k-1]:
  - If ce[k-1]: S[k] <= S[k-1] and V[k] <= V[k-1].
  - Otherwise S[k] and V[k] hold.
- Enables are independent, so a bubble or stall is permitted mid-pipe. A stage loads whatever its predecessor holds, even if that data is stale.
- Tap selection:
  - dout = S[DEPTH] and dout_valid = V[DEPTH].
  - dout_mult = S[min(tap_sel, DEPTH)]; tap_sel values above DEPTH clamp to DEPTH. mult_valid follows the same index.
  - cout = S[CASC_TAP]. A CASC_TAP value above DEPTH is an elaboration error.
- occupancy = popcount(V[1..DEPTH]); it is always 0 when DEPTH=0.
- DEPTH=0: all outputs are the combinational stage 0. clr and ce have no effect.
- Simultaneous clr and ce: clr wins, and every stage reads 0 with its valid bit at 0.

## Timing
- Reset values: all S[k]=0 and V[k]=0, so dout, cout (when CASC_TAP≥1), dout_mult (when tap≥1) are 0. dout_valid, mult_valid (when tap≥1) and occupancy are 0.
- Latency from din to dout is DEPTH edges with all ce=1; from din to the tap is tap edges.
- RST_n assertion clears outputs immediately, without waiting for a clock. Deassertion is synchronous to clk via the upstream reset synchroniser.
- Reset asserted mid-stream discards all in-flight operands. The first edge after release with ce=1 reloads stage 1 only.
- A change to tap_sel alters dout_mult in the same cycle, with no register on the select path.

## Structure
- Package dsp48_pkg holds:
  - constants MAX_OPERAND_W=30 and MAX_PIPE_DEPTH=4;
  - the INPUT_SEL string constants;
  - a function clamp_tap(sel, depth).
- One sub-module, dsp_pipe_stage: a single WIDTH+1-bit register with async reset, sync clear and enable. It is instantiated DEPTH times in a generate loop.
- Tap multiplexers and the occupancy popcount stay in the top level.

## Test plan
- Reset: drive din=18'h3FFFF with all ce=1, then assert RST_n=0 mid-cycle. dout, cout and dout_mult must be 0 and occupancy=0 before the next edge.
- Latency (DEPTH=2, DIRECT, tap_sel=1): din=5 with in_valid=1 at edge 1.
  - After edge 1: dout_mult=5 and mult_valid=1.
  - After edge 2: dout=5, dout_valid=1 and occupancy=2 (input held valid).
- Stall (DEPTH=3): load 7 then 9 with ce=3'b111, then ce=3'b101. Stage 2 must hold 7 while stage 3 loads 7. Then dout=7 and occupancy is unchanged.
- clr priority: with the pipe full of 12 and clr=1, ce=all ones at one edge, every stage must be 0, valids 0 and occupancy=0.
- Tap clamp and cascade (DEPTH=2, CASCADE, CASC_TAP=1): cin=100, then tap_sel=7. Required: dout_mult equals dout (stage 2), and cout=100 one edge after load. din is ignored.
- DEPTH=0: din=42 with in_valid=1. dout=42 and dout_valid=1 in the same cycle, regardless of clr and ce.
